jk_reg_bank: RTL and testbench

Parametrised bank of WIDTH independent flip-flops sharing one clock. Each bit is a JK flip-flop whose next-state function is selectable at run time as JK, D, T or SR. The bank adds per-bit synchronous preset, a global clock enable, a per-bit change pulse and a wrapping change-event counter. It is the general-purpose state-holding element for control and status registers in the flip-flop library, replacing single-bit instances.

---
 rtl/jk_pkg.sv | 12 +
 rtl/jk_next_bit.sv | 38 +++
 rtl/jk_reg_bank.sv | 84 ++++++++
 tb/tb_jk_reg_bank.sv | 139 +++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared mode encodings for the JK register bank.
// Imported by jk_next_bit and jk_reg_bank.
package jk_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_JK = 2'b00;
  localparam mode_t MODE_D  = 2'b01;
  localparam mode_t MODE_T  = 2'b10;
  localparam mode_t MODE_SR = 2'b11;

endpackage

// File: rtl/jk_next_bit.sv
// Combinational next-state of one flip-flop channel under the selected mode.
// Preset, clear and enable priority are applied by the caller.
module jk_next_bit
  import jk_pkg::*;
(
  input  logic  q,
  input  logic  j,
  input  logic  k,
  input  mode_t mode,
  output logic  q_next
);

  always_comb begin
    q_next = q;
    case (mode)
      MODE_JK: begin
        case ({j, k})
          2'b01:   q_next = 1'b0;
          2'b10:   q_next = 1'b1;
          2'b11:   q_next = ~q;
          default: q_next = q;
        endcase
      end
      MODE_D:  q_next = j;
      MODE_T:  q_next = j ? ~q : q;
      // SR 11 is illegal and holds; flagging is done in the bank.
      MODE_SR: begin
        case ({j, k})
          2'b10:   q_next = 1'b1;
          2'b01:   q_next = 1'b0;
          default: q_next = q;
        endcase
      end
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH run-time-configurable flip-flops with preset, enable, change
// pulses and a wrapping change counter. Optional sr_err under JKREG_SR_CHECK_EN.
module jk_reg_bank
  import jk_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               CNT_W   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] pre,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] chg,
  output logic [CNT_W-1:0] evt_cnt
`ifdef JKREG_SR_CHECK_EN
  ,
  output logic             sr_err
`endif
);

  // No handshake: every input is sampled on every rising edge; outputs are
  // valid continuously and reflect the most recent edge.

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_chg;
  logic [CNT_W-1:0] r_evt_cnt;
  logic [WIDTH-1:0] w_fn_next;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_chg_next;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    jk_next_bit u_next (
      .q      (r_q[g]),
      .j      (j[g]),
      .k      (k[g]),
      .mode   (mode),
      .q_next (w_fn_next[g])
    );
  end

  // Preset wins over the enabled function; disabled bits hold.
  assign w_q_next   = pre | (en ? w_fn_next : r_q);
  assign w_chg_next = w_q_next ^ r_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_q       <= RST_VAL;
      r_chg     <= '0;
      r_evt_cnt <= '0;
    end else begin
      r_q   <= w_q_next;
      r_chg <= w_chg_next;
      if (|w_chg_next) r_evt_cnt <= r_evt_cnt + CNT_ONE;
    end
  end

  assign q       = r_q;
  assign qbar    = ~r_q;
  assign chg     = r_chg;
  assign evt_cnt = r_evt_cnt;

`ifdef JKREG_SR_CHECK_EN
  logic r_sr_err;
  logic w_sr_illegal;

  assign w_sr_illegal = en && (mode == MODE_SR) && (|(j & k & ~pre));

  always_ff @(posedge clk) begin
    if (clr) r_sr_err <= 1'b0;
    else     r_sr_err <= r_sr_err | w_sr_illegal;
  end

  assign sr_err = r_sr_err;
`endif

endmodule

// File: tb/tb_jk_reg_bank.sv
// Scoreboard bench for jk_reg_bank (WIDTH=8, CNT_W=4, RST_VAL=0); sr_err is
// checked when JKREG_SR_CHECK_EN is defined.
module tb_jk_reg_bank;

  localparam int W  = 8;
  localparam int CW = 4;
  localparam int EW = 1 + W + W + CW;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          en  = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [W-1:0]  j = '0;
  logic [W-1:0]  k = '0;
  logic [W-1:0]  pre = '0;
  logic [W-1:0]  q;
  logic [W-1:0]  qbar;
  logic [W-1:0]  chg;
  logic [CW-1:0] evt_cnt;
`ifdef JKREG_SR_CHECK_EN
  logic          sr_err;
`endif

  logic [EW-1:0] exp_q[$];
  int            n_cmp = 0;
  int            n_mis = 0;
  int            n_pop = 0;

  jk_reg_bank #(.WIDTH(W), .CNT_W(CW), .RST_VAL(8'h00)) dut (
    .clk     (clk),
    .clr     (clr),
    .en      (en),
    .mode    (mode),
    .j       (j),
    .k       (k),
    .pre     (pre),
    .q       (q),
    .qbar    (qbar),
    .chg     (chg),
    .evt_cnt (evt_cnt)
`ifdef JKREG_SR_CHECK_EN
    ,
    .sr_err  (sr_err)
`endif
  );

  // clock
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s step %0d: got %h expected %h", name, n_pop, act, req);
    end
  endtask

  // monitor: one expected record per clock edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      e = exp_q.pop_front();
      check("q",       q,                  e[W+W+CW-1 -: W]);
      check("qbar",    qbar,               ~e[W+W+CW-1 -: W]);
      check("chg",     chg,                e[W+CW-1 -: W]);
      check("evt_cnt", {4'h0, evt_cnt},    {4'h0, e[CW-1:0]});
`ifdef JKREG_SR_CHECK_EN
      check("sr_err",  {7'h0, sr_err},     {7'h0, e[EW-1]});
`endif
      n_pop++;
    end
  end

  // driver: apply inputs on the falling edge, record expectation for next rising edge
  task automatic step(input logic c, input logic e_n, input logic [1:0] m,
                      input logic [W-1:0] jj, input logic [W-1:0] kk, input logic [W-1:0] pp,
                      input logic [W-1:0] xq, input logic [W-1:0] xchg,
                      input logic [CW-1:0] xcnt, input logic xerr);
    @(negedge clk);
    clr = c; en = e_n; mode = m; j = jj; k = kk; pre = pp;
    exp_q.push_back({xerr, xq, xchg, xcnt});
    @(posedge clk);
  endtask

  initial begin
    // reset with preset and enable also asserted
    step(1, 1, 2'b00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 4'd0, 0);
    // JK mode
    step(0, 1, 2'b00, 8'h0F, 8'h00, 8'h00, 8'h0F, 8'h0F, 4'd1, 0);
    step(0, 1, 2'b00, 8'hFF, 8'hFF, 8'h00, 8'hF0, 8'hFF, 4'd2, 0);
    step(0, 1, 2'b00, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h00, 4'd2, 0);
    // D, T, disabled
    step(0, 1, 2'b01, 8'hA5, 8'hFF, 8'h00, 8'hA5, 8'h55, 4'd3, 0);
    step(0, 1, 2'b10, 8'h0F, 8'hFF, 8'h00, 8'hAA, 8'h0F, 4'd4, 0);
    step(0, 0, 2'b10, 8'hFF, 8'h00, 8'h00, 8'hAA, 8'h00, 4'd4, 0);
    // SR set/reset on different bits, then JK reset of everything
    step(0, 1, 2'b11, 8'h01, 8'h80, 8'h00, 8'h2B, 8'h81, 4'd5, 0);
    step(0, 1, 2'b00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h2B, 4'd6, 0);
    // preset beats toggle; clr beats preset
    step(0, 1, 2'b00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 4'd7, 0);
    step(1, 1, 2'b00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 4'd0, 0);
    // preset acts with en=0; preset on an already-set bit shows no change
    step(0, 0, 2'b00, 8'h00, 8'h00, 8'h80, 8'h80, 8'h80, 4'd1, 0);
    step(0, 1, 2'b00, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 4'd1, 0);
    step(1, 0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0, 0);
    // counter wrap: 16 toggles of bit 0
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0]  xq;
      logic [CW-1:0] xc;
      xq = (i % 2 == 0) ? 8'h01 : 8'h00;
      xc = CW'((i + 1) % 16);
      step(0, 1, 2'b10, 8'h01, 8'h00, 8'h00, xq, 8'h01, xc, 0);
    end
    // SR illegal input holds and raises the sticky flag
    step(0, 1, 2'b01, 8'h3C, 8'h00, 8'h00, 8'h3C, 8'h3C, 4'd1, 0);
    step(0, 1, 2'b11, 8'h80, 8'h80, 8'h00, 8'h3C, 8'h00, 4'd1, 1);
    step(0, 1, 2'b11, 8'h01, 8'h00, 8'h00, 8'h3D, 8'h01, 4'd2, 1);
    step(0, 1, 2'b11, 8'h00, 8'h04, 8'h00, 8'h39, 8'h04, 4'd3, 1);
    step(1, 1, 2'b11, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 4'd0, 0);

    // drain: bounded wait for the monitor to consume everything
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
